// File: rtl/simple_st0_mem_ctrl_pkg.sv
// Shared types for the st0 tap/bias/data bank sequencer: memory control
// structs, FSM state encoding, host target selects and beat sideband tag.
package simple_st0_mem_ctrl_pkg;

  localparam int ST0_TAP_AW   = 5;
  localparam int ST0_BIAS_AW  = 4;
  localparam int ST0_DATA_AW  = 6;
  localparam int ST0_BEATS_W  = ST0_BIAS_AW + ST0_DATA_AW + 1;

  typedef struct packed {
    logic                  wr_en;
    logic [ST0_TAP_AW-1:0] wr_addr;
    logic                  rd_en;
    logic [ST0_TAP_AW-1:0] rd_addr;
  } tap_int_192_5;

  typedef struct packed {
    logic                   wr_en;
    logic [ST0_BIAS_AW-1:0] wr_addr;
    logic                   rd_en;
    logic [ST0_BIAS_AW-1:0] rd_addr;
  } bias_int_32_4;

  typedef struct packed {
    logic                   wr_en;
    logic [ST0_DATA_AW-1:0] wr_addr;
    logic                   rd_en;
    logic [ST0_DATA_AW-1:0] rd_addr;
  } data_int_32_6;

  typedef enum logic [1:0] {IDLE, BIAS, STREAM, DRAIN} st0_ctrl_state_t;

  localparam logic [1:0] HOST_SEL_DATA = 2'd0;
  localparam logic [1:0] HOST_SEL_TAP  = 2'd1;
  localparam logic [1:0] HOST_SEL_BIAS = 2'd2;
  localparam logic [1:0] HOST_SEL_RSVD = 2'd3;

  // fin marks the final beat of the whole run; it becomes done at the pipe exit
  typedef struct packed {
    logic                   first;
    logic                   last;
    logic                   fin;
    logic [ST0_BIAS_AW-1:0] out;
  } beat_tag_t;

  // A run must fit the tap memory linearly: (outs+1)*words taps words.
  function automatic logic cfg_illegal(input logic [ST0_DATA_AW-1:0] words,
                                       input logic [ST0_BIAS_AW-1:0] outs);
    logic [ST0_BEATS_W-1:0] beats;
    beats = (ST0_BEATS_W'(outs) + ST0_BEATS_W'(1)) * ST0_BEATS_W'(words);
    return (words == '0) || (beats > ST0_BEATS_W'(1 << ST0_TAP_AW));
  endfunction

endpackage

// File: rtl/simple_st0_mem_ctrl_pipe.sv
// Beat sideband delay line: stage 0 lines up with the registered rd_en,
// stage RD_LAT lines up with the returned read data. Flush clears everything.
module simple_st0_mem_ctrl_pipe
  import simple_st0_mem_ctrl_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      flush,
  input  logic      vld_in,
  input  beat_tag_t tag_in,
  output logic      vld_out,
  output beat_tag_t tag_out
);

  logic      [RD_LAT:0] vld_pipe;
  beat_tag_t [RD_LAT:0] tag_pipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[0] <= vld_in;
      tag_pipe[0] <= tag_in;
      for (int i = 1; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign vld_out = vld_pipe[RD_LAT];
  assign tag_out = tag_pipe[RD_LAT];

endmodule

// File: rtl/simple_st0_mem_ctrl.sv
// st0 bank sequencer: host writes while idle, then a run sweeps every output
// as one bias read followed by cfg_words paired data/tap reads.
module simple_st0_mem_ctrl
  import simple_st0_mem_ctrl_pkg::*;
#(
  parameter int TAP_AW  = ST0_TAP_AW,
  parameter int BIAS_AW = ST0_BIAS_AW,
  parameter int DATA_AW = ST0_DATA_AW,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [DATA_AW-1:0] cfg_words,
  input  logic [BIAS_AW-1:0] cfg_outs,
  input  logic               host_wr_valid,
  input  logic [1:0]         host_wr_sel,
  input  logic [DATA_AW-1:0] host_wr_addr,
  input  logic [191:0]       host_wr_data,
  output logic               host_wr_ready,
  input  logic               pe_ready,
  output tap_int_192_5       tap_int,
  output logic [191:0]       tap_int_wr_data,
  output bias_int_32_4       bias_int,
  output logic [31:0]        bias_int_wr_data,
  output data_int_32_6       data_int,
  output logic [31:0]        data_int_wr_data,
  output logic               beat_vld,
  output logic               beat_first,
  output logic               beat_last,
  output logic [BIAS_AW-1:0] beat_out,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam int DRAIN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  st0_ctrl_state_t    state, state_n;
  logic [DATA_AW-1:0] sh_words, word_idx;
  logic [BIAS_AW-1:0] sh_outs, out_idx;
  logic [TAP_AW-1:0]  tap_ptr;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               accept, host_xfer, issue_bias, issue_stream;
  logic               word_last, out_last, drain_end;
  logic               iss_vld;
  beat_tag_t          iss_tag, exit_tag;

  assign cfg_err       = cfg_illegal(cfg_words, cfg_outs);
  assign busy          = (state != IDLE);
  assign host_wr_ready = (state == IDLE);
  assign host_xfer     = host_wr_valid & host_wr_ready;
  assign accept        = (state == IDLE) & start & ~abort & ~cfg_err;
  assign word_last     = (word_idx == sh_words - DATA_AW'(1));
  assign out_last      = (out_idx == sh_outs);
  assign drain_end     = (drain_cnt == DRAIN_W'(RD_LAT - 1));

  always_comb begin
    state_n      = state;
    issue_bias   = 1'b0;
    issue_stream = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_n = BIAS;
        BIAS:    if (pe_ready) begin
                   issue_bias = 1'b1;
                   state_n    = STREAM;
                 end
        STREAM:  if (pe_ready) begin
                   issue_stream = 1'b1;
                   if (word_last) state_n = out_last ? DRAIN : BIAS;
                 end
        DRAIN:   if (drain_end) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sh_words  <= '0;
      sh_outs   <= '0;
      word_idx  <= '0;
      out_idx   <= '0;
      tap_ptr   <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        sh_words  <= cfg_words;
        sh_outs   <= cfg_outs;
        word_idx  <= '0;
        out_idx   <= '0;
        tap_ptr   <= '0;
        drain_cnt <= '0;
      end
      // tap_ptr keeps counting across outputs; the bank is laid out linearly
      if (issue_stream) begin
        tap_ptr  <= tap_ptr + TAP_AW'(1);
        word_idx <= word_last ? '0 : word_idx + DATA_AW'(1);
        if (word_last && !out_last) out_idx <= out_idx + BIAS_AW'(1);
      end
      if (state == DRAIN) drain_cnt <= drain_cnt + DRAIN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap_int          <= '0;
      bias_int         <= '0;
      data_int         <= '0;
      tap_int_wr_data  <= '0;
      bias_int_wr_data <= '0;
      data_int_wr_data <= '0;
    end else begin
      tap_int.rd_en  <= issue_stream;
      data_int.rd_en <= issue_stream;
      bias_int.rd_en <= issue_bias;
      if (issue_stream) begin
        tap_int.rd_addr  <= tap_ptr;
        data_int.rd_addr <= word_idx;
      end
      if (issue_bias) bias_int.rd_addr <= out_idx;

      // host writes only land in IDLE, so they can never collide with reads
      tap_int.wr_en  <= host_xfer && (host_wr_sel == HOST_SEL_TAP);
      bias_int.wr_en <= host_xfer && (host_wr_sel == HOST_SEL_BIAS);
      data_int.wr_en <= host_xfer && (host_wr_sel == HOST_SEL_DATA);
      if (host_xfer && host_wr_sel == HOST_SEL_TAP) begin
        tap_int.wr_addr <= host_wr_addr[TAP_AW-1:0];
        tap_int_wr_data <= host_wr_data;
      end
      if (host_xfer && host_wr_sel == HOST_SEL_BIAS) begin
        bias_int.wr_addr <= host_wr_addr[BIAS_AW-1:0];
        bias_int_wr_data <= host_wr_data[31:0];
      end
      if (host_xfer && host_wr_sel == HOST_SEL_DATA) begin
        data_int.wr_addr <= host_wr_addr;
        data_int_wr_data <= host_wr_data[31:0];
      end
    end
  end

  always_comb begin
    iss_vld = issue_bias | issue_stream;
    iss_tag = '0;
    if (issue_stream) begin
      iss_tag.first = (word_idx == '0);
      iss_tag.last  = word_last;
      iss_tag.fin   = word_last & out_last;
    end
    if (iss_vld) iss_tag.out = out_idx;
  end

  simple_st0_mem_ctrl_pipe #(.RD_LAT(RD_LAT)) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .flush   (abort),
    .vld_in  (iss_vld),
    .tag_in  (iss_tag),
    .vld_out (beat_vld),
    .tag_out (exit_tag)
  );

  assign beat_first = exit_tag.first;
  assign beat_last  = exit_tag.last;
  assign beat_out   = exit_tag.out;
  assign done       = beat_vld & exit_tag.fin;

endmodule
